// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the pointer-to-occupancy helper used by the
// controller and the 8x8 memory it drives.
package fifo_pkg;

  localparam int FIFO_DEPTH    = 8;
  localparam int FIFO_ADDR_W   = 3;
  localparam int DATA_W        = 8;
  localparam int FIFO_AF_LEVEL = 6;
  localparam int FIFO_AE_LEVEL = 2;

  typedef logic [FIFO_ADDR_W:0] ptr_t;

  // Pointers carry one extra wrap bit, so plain modular subtraction yields 0..DEPTH.
  function automatic ptr_t fifo_count(input ptr_t wr_ptr, input ptr_t rd_ptr);
    return wr_ptr - rd_ptr;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Request and status bundle between a FIFO user and sync_fifo_ctrl.
interface sync_fifo_ctrl_if;
  import fifo_pkg::*;

  logic                   flush_i;
  logic                   wr_en_i;
  logic                   rd_en_i;
  logic                   mem_wr_en_o;
  logic [FIFO_ADDR_W-1:0] mem_wr_addr_o;
  logic                   mem_rd_en_o;
  logic [FIFO_ADDR_W-1:0] mem_rd_addr_o;
  logic                   rd_valid_o;
  logic                   full_o;
  logic                   empty_o;
  logic                   almost_full_o;
  logic                   almost_empty_o;
  logic [FIFO_ADDR_W:0]   count_o;
  logic                   overflow_o;
  logic                   underflow_o;

  modport master (
    output flush_i, wr_en_i, rd_en_i,
    input  mem_wr_en_o, mem_wr_addr_o, mem_rd_en_o, mem_rd_addr_o, rd_valid_o,
    input  full_o, empty_o, almost_full_o, almost_empty_o, count_o,
    input  overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, wr_en_i, rd_en_i,
    output mem_wr_en_o, mem_wr_addr_o, mem_rd_en_o, mem_rd_addr_o, rd_valid_o,
    output full_o, empty_o, almost_full_o, almost_empty_o, count_o,
    output overflow_o, underflow_o
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: increments on i_inc, synchronous clear on i_clr.
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_ptr <= '0;
    else if (i_clr) r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + 1'b1;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, status flags, sticky errors and a
// read-valid strobe aligned with the memory's registered read data.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = FIFO_AF_LEVEL,
  parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_ctrl_if.slave  bus
);

  if ((DEPTH != (1 << ADDR_W)) || (DEPTH < 4) || (ADDR_W != FIFO_ADDR_W)) begin : g_bad_cfg
    $error("sync_fifo_ctrl: DEPTH must be 2**ADDR_W, >= 4, and match fifo_pkg");
  end

  logic [ADDR_W:0] w_wr_ptr;
  logic [ADDR_W:0] w_rd_ptr;
  logic [ADDR_W:0] w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_wr_acc;
  logic            w_rd_acc;
  logic            r_rd_valid_p1;
  logic            r_overflow;
  logic            r_underflow;

  // Flags depend only on registered pointers, never on the request inputs.
  assign w_full   = (w_wr_ptr[ADDR_W] != w_rd_ptr[ADDR_W]) &&
                    (w_wr_ptr[ADDR_W-1:0] == w_rd_ptr[ADDR_W-1:0]);
  assign w_empty  = (w_wr_ptr == w_rd_ptr);
  assign w_count  = fifo_count(w_wr_ptr, w_rd_ptr);

  assign w_wr_acc = bus.wr_en_i & ~w_full  & ~bus.flush_i;
  assign w_rd_acc = bus.rd_en_i & ~w_empty & ~bus.flush_i;

  fifo_ptr #(.W(ADDR_W + 1)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_wr_acc),
    .i_clr (bus.flush_i),
    .o_ptr (w_wr_ptr)
  );

  fifo_ptr #(.W(ADDR_W + 1)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_rd_acc),
    .i_clr (bus.flush_i),
    .o_ptr (w_rd_ptr)
  );

  // p0 -> p1: memory read issued this cycle, data_o valid next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid_p1 <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else if (bus.flush_i) begin
      r_rd_valid_p1 <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_rd_valid_p1 <= w_rd_acc;
      if (bus.wr_en_i && w_full)  r_overflow  <= 1'b1;
      if (bus.rd_en_i && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.mem_wr_en_o    = w_wr_acc;
  assign bus.mem_rd_en_o    = w_rd_acc;
  assign bus.mem_wr_addr_o  = w_wr_ptr[ADDR_W-1:0];
  assign bus.mem_rd_addr_o  = w_rd_ptr[ADDR_W-1:0];
  assign bus.rd_valid_o     = r_rd_valid_p1;
  assign bus.full_o         = w_full;
  assign bus.empty_o        = w_empty;
  assign bus.count_o        = w_count;
  assign bus.almost_full_o  = (w_count >= (ADDR_W + 1)'(AF_LEVEL));
  assign bus.almost_empty_o = (w_count <= (ADDR_W + 1)'(AE_LEVEL));
  assign bus.overflow_o     = r_overflow;
  assign bus.underflow_o    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomized scoreboard bench for sync_fifo_ctrl with a behavioural 8x8
// registered-output memory hung off the strobes.
module tb_sync_fifo_ctrl;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_ctrl_if bus ();

  sync_fifo_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_dout;

  always @(posedge clk) begin
    if (bus.mem_wr_en_o) mem[bus.mem_wr_addr_o] <= mem_din;
    if (bus.mem_rd_en_o) mem_dout <= mem[bus.mem_rd_addr_o];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO contents as a queue plus totals of accepted operations.
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int wr_tot = 0;
  int rd_tot = 0;
  bit m_ovf = 0;
  bit m_udf = 0;
  bit m_prev_rd = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    wr_tot = 0;
    rd_tot = 0;
    m_ovf = 0;
    m_udf = 0;
    m_prev_rd = 0;
  endtask

  task automatic check_state(input bit wacc, input bit racc);
    int sz;
    sz = model_q.size();
    chk("count",        int'(bus.count_o),        sz);
    chk("full",         int'(bus.full_o),         int'(sz == FIFO_DEPTH));
    chk("empty",        int'(bus.empty_o),        int'(sz == 0));
    chk("almost_full",  int'(bus.almost_full_o),  int'(sz >= FIFO_AF_LEVEL));
    chk("almost_empty", int'(bus.almost_empty_o), int'(sz <= FIFO_AE_LEVEL));
    chk("mem_wr_en",    int'(bus.mem_wr_en_o),    int'(wacc));
    chk("mem_rd_en",    int'(bus.mem_rd_en_o),    int'(racc));
    chk("mem_wr_addr",  int'(bus.mem_wr_addr_o),  wr_tot % FIFO_DEPTH);
    chk("mem_rd_addr",  int'(bus.mem_rd_addr_o),  rd_tot % FIFO_DEPTH);
    chk("rd_valid",     int'(bus.rd_valid_o),     int'(m_prev_rd));
    chk("overflow",     int'(bus.overflow_o),     int'(m_ovf));
    chk("underflow",    int'(bus.underflow_o),    int'(m_udf));
  endtask

  task automatic cycle(input bit w, input bit r, input bit f, input logic [DATA_W-1:0] d);
    int sz;
    bit wacc;
    bit racc;
    @(posedge clk);
    #1;
    bus.wr_en_i = w;
    bus.rd_en_i = r;
    bus.flush_i = f;
    mem_din     = d;
    @(negedge clk);
    sz   = model_q.size();
    wacc = w && !f && (sz < FIFO_DEPTH);
    racc = r && !f && (sz > 0);
    check_state(wacc, racc);
    if (f) begin
      model_q.delete();
      wr_tot = 0;
      rd_tot = 0;
      m_ovf = 0;
      m_udf = 0;
      m_prev_rd = 0;
    end else begin
      if (w && sz == FIFO_DEPTH) m_ovf = 1;
      if (r && sz == 0)          m_udf = 1;
      if (racc) begin
        exp_q.push_back(model_q.pop_front());
        rd_tot++;
      end
      if (wacc) begin
        model_q.push_back(d);
        wr_tot++;
      end
      m_prev_rd = racc;
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #1;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_state(1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every presented read word must be the oldest outstanding pop.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid_o) begin
      if (exp_q.size() == 0) chk("rd_valid_unexpected", 1, 0);
      else                   chk("rd_data", int'(mem_dout), int'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.flush_i = 1'b0;
    mem_din     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state(1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    repeat (2) cycle(0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'h10 + 8'(i));
    cycle(1, 0, 0, 8'hEE);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 8'h00);
    cycle(0, 1, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 1, 8'h00);

    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'h20 + 8'(i));
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 8'h30 + 8'(i));
    cycle(0, 1, 0, 8'h00);
    cycle(0, 1, 0, 8'h00);
    cycle(1, 1, 0, 8'h40);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'h50 + 8'(i));
    cycle(1, 1, 0, 8'h5F);
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 8'h00);
    cycle(1, 1, 0, 8'h60);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'h70 + 8'(i));
    cycle(0, 1, 0, 8'h00);
    cycle(1, 1, 1, 8'h7F);
    repeat (2) cycle(0, 0, 0, 8'h00);

    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 8'h80 + 8'(i));
    async_reset();
    cycle(0, 0, 0, 8'h00);

    for (int i = 0; i < 600; i++) begin
      bit fill;
      fill = ((i / 40) % 2) == 0;
      cycle(fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            fill ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 59) == 0),
            8'($urandom));
    end

    repeat (3) cycle(0, 0, 0, 8'h00);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
